iiitb_qdec: RTL and testbench

Quadrature decoder for the 4-bit up/down counter family: it accepts the two-phase A/B outputs of an incremental encoder and derives the direction and step events that the counter side consumes. The block synchronizes and glitch-filters both phases, decodes Gray-code transitions, and maintains its own wrap-around 4-bit position count. It sits between the asynchronous encoder pins and the counter/position logic, and it flags illegal two-phase jumps.

---
 rtl/iiitb_qdec.sv | 100 ++++++++++
 tb/tb_iiitb_qdec.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/iiitb_qdec.sv
// rtl/iiitb_qdec.sv - quadrature decoder: A/B synchronizer, glitch filter, Gray decode, 4-bit position
module iiitb_qdec #(
  parameter int FILTER = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       ErrClr,
  output logic [3:0] Count,
  output logic       Dir,
  output logic       Step,
  output logic       Err,
  output logic       ErrSticky
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

  logic [1:0] s1, s2, f;
  logic [3:0] cnt;
  logic [1:0] warm;
  logic       init;

  logic settled, differs, stable, at_limit, accept;
  logic is_up, is_down, is_jump;

  always_comb begin
    // s2 still holds reset values for the first two edges, so pin state is not trusted until then
    settled  = (warm == 2'd2);
    differs  = (s2 != f);
    stable   = (s2 == s1);
    at_limit = (cnt == FILT_LAST);
    accept   = settled && differs && stable && at_limit;
    is_up    = 1'b0;
    is_down  = 1'b0;
    case (f)
      2'b00: begin is_up = (s2 == 2'b10); is_down = (s2 == 2'b01); end
      2'b10: begin is_up = (s2 == 2'b11); is_down = (s2 == 2'b00); end
      2'b11: begin is_up = (s2 == 2'b01); is_down = (s2 == 2'b10); end
      default: begin is_up = (s2 == 2'b00); is_down = (s2 == 2'b11); end
    endcase
    is_jump = ((s2 ^ f) == 2'b11);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1        <= 2'b00;
      s2        <= 2'b00;
      f         <= 2'b00;
      cnt       <= 4'd0;
      warm      <= 2'd0;
      init      <= 1'b1;
      Count     <= 4'd0;
      Dir       <= 1'b0;
      Step      <= 1'b0;
      Err       <= 1'b0;
      ErrSticky <= 1'b0;
    end else begin
      s1   <= {A, B};
      s2   <= s1;
      Step <= 1'b0;
      Err  <= 1'b0;
      if (!settled)
        warm <= warm + 2'd1;

      if (settled && differs && stable) begin
        if (at_limit) begin
          f   <= s2;
          cnt <= 4'd0;
          if (init) begin
            init <= 1'b0;
          end else if (is_up) begin
            Count <= Count + 4'd1;
            Dir   <= 1'b1;
            Step  <= 1'b1;
          end else if (is_down) begin
            Count <= Count - 4'd1;
            Dir   <= 1'b0;
            Step  <= 1'b1;
          end else if (is_jump) begin
            Err <= 1'b1;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
        if (settled && init && !differs && cnt == 4'd0)
          init <= 1'b0;
      end

      // a new error on the same edge as ErrClr keeps the flag set
      if (accept && !init && is_jump)
        ErrSticky <= 1'b1;
      else if (ErrClr)
        ErrSticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iiitb_qdec.sv
// tb/tb_iiitb_qdec.sv - directed self-checking bench for iiitb_qdec
module tb_iiitb_qdec;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       A = 1'b1;
  logic       B = 1'b1;
  logic       ErrClr = 1'b0;
  logic [3:0] Count;
  logic       Dir, Step, Err, ErrSticky;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int err_cnt = 0;

  iiitb_qdec #(.FILTER(2)) dut (
    .Clk(Clk), .reset(reset), .A(A), .B(B), .ErrClr(ErrClr),
    .Count(Count), .Dir(Dir), .Step(Step), .Err(Err), .ErrSticky(ErrSticky)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Step) step_cnt = step_cnt + 1;
    if (Err) err_cnt = err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_ab(input logic a, input logic b);
    @(posedge Clk);
    #1;
    A = a;
    B = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; A = 1'b1; B = 1'b1;
    tick(2);
    total++; if (Count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", Count); end
    total++; if ({Dir, Step, Err, ErrSticky} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", {Dir, Step, Err, ErrSticky}); end
    reset = 1'b0;
    step_cnt = 0; err_cnt = 0;
    tick(10);
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL init_err: got %0d want 0", err_cnt); end
    total++; if (step_cnt !== 0) begin bad++; $display("FAIL init_step: got %0d want 0", step_cnt); end
    total++; if (Count !== 4'd0) begin bad++; $display("FAIL init_count: got %0d want 0", Count); end
    total++; if (ErrSticky !== 1'b0) begin bad++; $display("FAIL init_sticky: got %b want 0", ErrSticky); end
    // 11 must have been loaded as the filtered state, so 11->01 is an up-step
    set_ab(1'b0, 1'b1);
    tick(4);
    total++; if ({Step, Count, Dir} !== {1'b1, 4'd1, 1'b1}) begin bad++; $display("FAIL init_first_step: got step=%b count=%0d dir=%b want 1 1 1", Step, Count, Dir); end
    reset = 1'b1; A = 1'b0; B = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(6);
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    step_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      set_ab(seq[i % 4][1], seq[i % 4][0]);
      tick(3);
      total++; if (Step !== 1'b0) begin bad++; $display("FAIL fwd_early_%0d: got %b want 0", i, Step); end
      tick(1);
      total++; if (Step !== 1'b1) begin bad++; $display("FAIL fwd_step_%0d: got %b want 1", i, Step); end
      total++; if (Count !== 4'((i + 1) % 16)) begin bad++; $display("FAIL fwd_count_%0d: got %0d want %0d", i, Count, (i + 1) % 16); end
      total++; if (Dir !== 1'b1) begin bad++; $display("FAIL fwd_dir_%0d: got %b want 1", i, Dir); end
      tick(1);
      total++; if (Step !== 1'b0) begin bad++; $display("FAIL fwd_width_%0d: got %b want 0", i, Step); end
      tick(3);
    end
    total++; if (step_cnt !== 16) begin bad++; $display("FAIL fwd_pulses: got %0d want 16", step_cnt); end
  endtask

  task automatic test_reverse();
    set_ab(1'b0, 1'b1);
    tick(4);
    total++; if ({Step, Count, Dir} !== {1'b1, 4'd15, 1'b0}) begin bad++; $display("FAIL rev_wrap: got step=%b count=%0d dir=%b want 1 15 0", Step, Count, Dir); end
    tick(4);
    set_ab(1'b1, 1'b1); tick(8);
    set_ab(1'b1, 1'b0); tick(8);
    set_ab(1'b0, 1'b0); tick(8);
    total++; if ({Count, Dir} !== {4'd12, 1'b0}) begin bad++; $display("FAIL rev_count: got count=%0d dir=%b want 12 0", Count, Dir); end
  endtask

  task automatic test_glitch();
    step_cnt = 0; err_cnt = 0;
    set_ab(1'b1, 1'b0);
    tick(1);
    set_ab(1'b0, 1'b0);
    tick(10);
    total++; if ({step_cnt, err_cnt} !== {32'd0, 32'd0}) begin bad++; $display("FAIL glitch_short: got steps=%0d errs=%0d want 0 0", step_cnt, err_cnt); end
    total++; if (Count !== 4'd12) begin bad++; $display("FAIL glitch_short_count: got %0d want 12", Count); end
    set_ab(1'b1, 1'b0);
    tick(3);
    set_ab(1'b0, 1'b0);
    tick(12);
    total++; if (step_cnt !== 2) begin bad++; $display("FAIL glitch_long_steps: got %0d want 2", step_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL glitch_long_errs: got %0d want 0", err_cnt); end
    total++; if ({Count, Dir} !== {4'd12, 1'b0}) begin bad++; $display("FAIL glitch_long_count: got count=%0d dir=%b want 12 0", Count, Dir); end
  endtask

  task automatic test_illegal();
    err_cnt = 0; step_cnt = 0;
    set_ab(1'b1, 1'b1);
    tick(3);
    total++; if (Err !== 1'b0) begin bad++; $display("FAIL jump_early: got %b want 0", Err); end
    tick(1);
    total++; if ({Err, Step, ErrSticky} !== 3'b101) begin bad++; $display("FAIL jump_flags: got err=%b step=%b sticky=%b want 1 0 1", Err, Step, ErrSticky); end
    total++; if ({Count, Dir} !== {4'd12, 1'b0}) begin bad++; $display("FAIL jump_hold: got count=%0d dir=%b want 12 0", Count, Dir); end
    tick(6);
    total++; if ({err_cnt, step_cnt} !== {32'd1, 32'd0}) begin bad++; $display("FAIL jump_pulses: got errs=%0d steps=%0d want 1 0", err_cnt, step_cnt); end
    set_ab(1'b0, 1'b1);
    tick(4);
    total++; if ({Step, Count, Dir} !== {1'b1, 4'd13, 1'b1}) begin bad++; $display("FAIL jump_recover: got step=%b count=%0d dir=%b want 1 13 1", Step, Count, Dir); end
    tick(4);
  endtask

  task automatic test_races();
    set_ab(1'b1, 1'b0);
    tick(3);
    ErrClr = 1'b1;
    tick(1);
    total++; if ({Err, ErrSticky} !== 2'b11) begin bad++; $display("FAIL race_set_wins: got err=%b sticky=%b want 1 1", Err, ErrSticky); end
    ErrClr = 1'b0;
    tick(2);
    ErrClr = 1'b1;
    tick(1);
    total++; if (ErrSticky !== 1'b0) begin bad++; $display("FAIL race_clear: got %b want 0", ErrSticky); end
    ErrClr = 1'b0;
    tick(3);
    set_ab(1'b0, 1'b1);
    tick(4);
    total++; if (ErrSticky !== 1'b1) begin bad++; $display("FAIL race_resticky: got %b want 1", ErrSticky); end
    set_ab(1'b0, 1'b0);
    tick(4);
    total++; if ({Step, Count, Dir} !== {1'b1, 4'd14, 1'b1}) begin bad++; $display("FAIL race_prestep: got step=%b count=%0d dir=%b want 1 14 1", Step, Count, Dir); end
    set_ab(1'b1, 1'b0);
    tick(1);
    #2 reset = 1'b1;
    #1;
    total++; if (Count !== 4'd0) begin bad++; $display("FAIL async_count: got %0d want 0", Count); end
    total++; if ({Dir, Step, Err, ErrSticky} !== 4'b0000) begin bad++; $display("FAIL async_flags: got %b want 0000", {Dir, Step, Err, ErrSticky}); end
    tick(2);
    reset = 1'b0;
    step_cnt = 0; err_cnt = 0;
    tick(10);
    total++; if ({step_cnt, err_cnt} !== {32'd0, 32'd0}) begin bad++; $display("FAIL async_discard: got steps=%0d errs=%0d want 0 0", step_cnt, err_cnt); end
    total++; if (Count !== 4'd0) begin bad++; $display("FAIL async_after_count: got %0d want 0", Count); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_races();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
